mem_stage: RTL and testbench

- Memory-access stage of the 5-stage MIPS R2000 pipeline, between the EX/MEM boundary and the writeback stage.
- Performs loads and stores (byte, halfword, word; signed/unsigned) against an internal word-organised data RAM.
- Owns the MEM/WB pipeline register, driving read_data, address_WB, wb and reg_WB straight into writeback.
- Supports stall, flush and misaligned-access squash.

---
 rtl/mem_stage.sv | 69 ++++++
 tb/tb_mem_stage.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with byte-lane data RAM, misalignment squash and MEM/WB register.
module mem_stage #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [1:0]  wb_MEM,
  input  logic [31:0] address_MEM,
  input  logic [31:0] write_data_MEM,
  input  logic [4:0]  reg_MEM,
  output logic [31:0] read_data,
  output logic [31:0] address_WB,
  output logic [1:0]  wb,
  output logic [4:0]  reg_WB,
  output logic        misaligned
);
  logic [31:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic is_word, is_half, mis, we;
  logic [3:0] be;
  logic [31:0] wdata, word, load, rdata;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  always_comb begin
    idx = address_MEM[ADDR_W+1:2];
    is_word = mem_size[1];
    is_half = mem_size == 2'b01;
    mis = (mem_read | mem_write) &
          (is_word ? |address_MEM[1:0] : is_half ? address_MEM[0] : 1'b0);
    we = mem_write & ~mis & ~stall & ~flush & ~rst;
    be = is_word ? 4'b1111 : is_half ? (address_MEM[1] ? 4'b1100 : 4'b0011)
                                     : 4'b0001 << address_MEM[1:0];
    wdata = is_word ? write_data_MEM : is_half ? {2{write_data_MEM[15:0]}}
                                               : {4{write_data_MEM[7:0]}};
    word = mem[idx];
    lane_b = word[8*address_MEM[1:0] +: 8];
    lane_h = word[16*address_MEM[1] +: 16];
    load = is_word ? word
         : is_half ? {{16{~mem_unsigned & lane_h[15]}}, lane_h}
                   : {{24{~mem_unsigned & lane_b[7]}}, lane_b};
    rdata = (mem_read & ~mem_write & ~mis) ? load : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (we)
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      read_data  <= '0;
      address_WB <= '0;
      wb         <= '0;
      reg_WB     <= '0;
      misaligned <= 1'b0;
    end else if (!stall) begin
      read_data  <= rdata;
      address_WB <= address_MEM;
      wb         <= mis ? 2'b00 : wb_MEM;
      reg_WB     <= reg_MEM;
      misaligned <= mis;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random checks of mem_stage against a byte-addressed memory model.
module tb_mem_stage;
  logic clk = 0, rst, stall, flush, mem_read, mem_write, mem_unsigned;
  logic [1:0] mem_size, wb_MEM, wb;
  logic [31:0] address_MEM, write_data_MEM, read_data, address_WB;
  logic [4:0] reg_MEM, reg_WB;
  logic misaligned;
  int n_chk = 0, n_fail = 0;
  logic [7:0] mb [4096];
  bit known [4096];
  logic [31:0] e_rd, e_addr;
  logic [1:0] e_wb;
  logic [4:0] e_reg;
  logic e_mis;
  bit rd_ok;

  mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .wb_MEM(wb_MEM), .address_MEM(address_MEM),
    .write_data_MEM(write_data_MEM), .reg_MEM(reg_MEM), .read_data(read_data),
    .address_WB(address_WB), .wb(wb), .reg_WB(reg_WB), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic w, input logic [1:0] sz, input logic u,
                       input logic [1:0] wbm, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rg, input logic st = 0, input logic fl = 0,
                       input logic rs = 0);
    int nb;
    bit mis, ok;
    logic [31:0] v;
    mem_read = r; mem_write = w; mem_size = sz; mem_unsigned = u; wb_MEM = wbm;
    address_MEM = a; write_data_MEM = wd; reg_MEM = rg; stall = st; flush = fl; rst = rs;
    @(posedge clk);
    nb = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    mis = (r || w) && (a % nb != 0);
    if (rs || fl) begin
      e_rd = 0; e_addr = 0; e_wb = 0; e_reg = 0; e_mis = 0; rd_ok = 1;
    end else if (!st) begin
      v = 0; ok = 1;
      if (r && !w && !mis) begin
        for (int i = 0; i < nb; i++) begin
          v |= 32'(mb[(a[11:0] + i) % 4096]) << (8 * i);
          ok &= known[(a[11:0] + i) % 4096];
        end
        if (!u && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
      end
      e_rd = v; rd_ok = ok; e_addr = a; e_wb = mis ? 2'b00 : wbm; e_reg = rg; e_mis = mis;
      if (w && !mis)
        for (int i = 0; i < nb; i++) begin
          mb[(a[11:0] + i) % 4096] = wd[8*i +: 8];
          known[(a[11:0] + i) % 4096] = 1;
        end
    end
    #1;
    if (rd_ok) chk("read_data", read_data, e_rd);
    chk("address_WB", address_WB, e_addr);
    chk("wb", 32'(wb), 32'(e_wb));
    chk("reg_WB", 32'(reg_WB), 32'(e_reg));
    chk("misaligned", 32'(misaligned), 32'(e_mis));
  endtask

  initial begin
    logic [31:0] hold_addr;
    cycle(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 2, 0, 0, 0, 0, 0);
    chk("reset_wb", 32'(wb), 0);
    cycle(0, 1, 2, 0, 2'b00, 32'h10, 32'hDEADBEEF, 0);
    cycle(1, 0, 2, 0, 2'b11, 32'h10, 0, 5);
    chk("lw_data", read_data, 32'hDEADBEEF);
    chk("lw_reg", 32'(reg_WB), 5);
    cycle(0, 1, 2, 0, 0, 32'h10, 32'h11223344, 0);
    cycle(0, 1, 0, 0, 0, 32'h11, 32'h00000080, 0);
    cycle(1, 0, 0, 0, 2'b11, 32'h11, 0, 3);
    chk("lb_const", read_data, 32'hFFFFFF80);
    cycle(1, 0, 0, 1, 2'b11, 32'h11, 0, 3);
    chk("lbu_const", read_data, 32'h00000080);
    cycle(1, 0, 2, 0, 2'b11, 32'h10, 0, 3);
    chk("lw_after_sb", read_data, 32'h11228044);
    cycle(0, 1, 2, 0, 0, 32'h10, 32'h0, 0);
    cycle(0, 1, 1, 0, 0, 32'h12, 32'h0000BEEF, 0);
    cycle(1, 0, 1, 0, 2'b11, 32'h12, 0, 4);
    chk("lh_const", read_data, 32'hFFFFBEEF);
    cycle(1, 0, 1, 1, 2'b11, 32'h12, 0, 4);
    cycle(1, 0, 2, 0, 2'b11, 32'h10, 0, 4);
    chk("lw_after_sh", read_data, 32'hBEEF0000);
    cycle(1, 0, 2, 0, 2'b11, 32'h13, 0, 7);
    chk("mis_flag", 32'(misaligned), 1);
    cycle(0, 0, 2, 0, 2'b10, 32'h40, 0, 8);
    chk("mis_one_cycle", 32'(misaligned), 0);
    cycle(0, 1, 2, 0, 0, 32'h00, 32'hCAFEF00D, 0);
    cycle(0, 1, 2, 0, 0, 32'h02, 32'h12345678, 0);
    cycle(1, 0, 2, 0, 2'b11, 32'h00, 0, 9);
    chk("mis_store_blocked", read_data, 32'hCAFEF00D);
    cycle(0, 1, 2, 0, 0, 32'h20, 32'h55AA55AA, 0);
    hold_addr = address_WB;
    cycle(0, 1, 2, 0, 2'b10, 32'h20, 32'h1, 1, 1);
    cycle(0, 1, 2, 0, 2'b10, 32'h20, 32'h1, 1, 1);
    chk("stall_hold", address_WB, hold_addr);
    cycle(0, 1, 2, 0, 2'b10, 32'h20, 32'h2, 1, 0, 1);
    cycle(1, 0, 2, 0, 2'b11, 32'h20, 0, 2);
    chk("stall_flush_no_write", read_data, 32'h55AA55AA);
    cycle(0, 1, 2, 0, 0, 32'h20, 32'h77, 0, 0, 0, 1);
    cycle(1, 0, 2, 0, 2'b11, 32'h20, 0, 2);
    chk("rst_no_write", read_data, 32'h55AA55AA);
    for (int i = 0; i < 16; i++) cycle(0, 1, 2, 0, 0, 32'(4 * i), $urandom, 0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, d;
      logic [3:0] sel;
      a = $urandom & 32'hFFFF_F03F;
      d = $urandom;
      sel = 4'($urandom);
      cycle(sel[0], sel[1] & sel[2], 2'($urandom), 1'($urandom), 2'($urandom), a, d,
            5'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 31) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
